// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Owns the single write port of the 4x16-bit register file. Two writeback
//   requesters (req0 = execute, req1 = load return) compete for the port; the
//   winner is written through a one-cycle registered output stage. A small
//   pending-write scoreboard (one saturating counter per register) lets decode
//   stall on RAW hazards via busy[].
//
//   Configuration macro: RF_ARB_ROUND_ROBIN_EN
//     undefined : fixed priority, req0 over req1 (no pointer register)
//     defined   : round-robin between the two requesters using a 1-bit
//                 last-grant pointer; req0 wins the first contention after reset
//
//   Ports
//     clk, reset                  clock, synchronous active-high reset
//     req0_valid/ready/addr/data  execute writeback request
//     req1_valid/ready/addr/data  load writeback request
//     rsv_valid/ready/addr        decode reservation of a destination register
//     rf_write/_addr/_data        register file write port (registered)
//     busy[NREG]                  register i has pending writes
//
//   Handshake: a transfer happens on a cycle where valid && ready are both
//   high. The arbiter grants at most one requester per cycle; the loser sees
//   ready=0 and must keep valid/addr/data stable until accepted. Ready depends
//   only on the valids and arbitration state, never on a requester's data.
//   rsv_ready depends on rsv_addr, since it selects the counter being checked.
module rf_write_arbiter #(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 2,
   parameter  int CNT_W  = 2,
   localparam int NREG   = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              rsv_ready,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic [NREG-1:0]   busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              prio0;     // req0 wins when both requesters are valid
   logic              grant0;
   logic              grant1;
   logic              wb_fire;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              rsv_fire;
   logic [NREG-1:0]   inc;
   logic [NREG-1:0]   dec;
   logic [CNT_W-1:0]  count     [NREG];
   logic [CNT_W-1:0]  count_nxt [NREG];

`ifdef RF_ARB_ROUND_ROBIN_EN
   // 1 = req1 was granted most recently. Resetting to 1 gives req0 the
   // first contention. Only real acceptances move the pointer.
   logic last_grant1;

   always_ff @(posedge clk) begin
      if (reset)       last_grant1 <= 1'b1;
      else if (grant0) last_grant1 <= 1'b0;
      else if (grant1) last_grant1 <= 1'b1;
   end

   assign prio0 = last_grant1;
`else
   assign prio0 = 1'b1;
`endif

   // A lone valid requester is always granted; contention is settled by prio0.
   assign grant0     = req0_valid && (!req1_valid || prio0);
   assign grant1     = req1_valid && !grant0;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign wb_fire = grant0 || grant1;
   assign wb_addr = grant0 ? req0_addr : req1_addr;
   assign wb_data = grant0 ? req0_data : req1_data;

   // A full counter can still take a reservation when a writeback to the same
   // register retires in this cycle: the two cancel and the count stays put.
   assign rsv_ready = (count[rsv_addr] != CNT_MAX) || (wb_fire && (wb_addr == rsv_addr));
   assign rsv_fire  = rsv_valid && rsv_ready;

   assign inc = rsv_fire ? (NREG'(1) << rsv_addr) : '0;
   assign dec = wb_fire  ? (NREG'(1) << wb_addr)  : '0;

   // Counters retire on acceptance rather than on rf_write so busy drops as
   // early as possible. A writeback to an unreserved register floors at 0.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         count_nxt[i] = count[i];
         if (inc[i] && !dec[i]) begin
            count_nxt[i] = count[i] + CNT_W'(1);
         end else if (dec[i] && !inc[i] && (count[i] != '0)) begin
            count_nxt[i] = count[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (reset) count[i] <= '0;
         else       count[i] <= count_nxt[i];
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NREG; i++) begin
         busy[i] = (count[i] != '0);
      end
   end

   // Output stage: one cycle latency; addr/data hold when nothing is written.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write      <= 1'b0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
      end else begin
         rf_write <= wb_fire;
         if (wb_fire) begin
            rf_write_addr <= wb_addr;
            rf_write_data <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed walk through the write arbiter's key scenarios followed by a
//   randomized phase. A reference model updated on the falling edge predicts
//   grants, rsv_ready and busy, and queues every expected register-file write;
//   an independent monitor pops that queue whenever the write port is sampled.
module tb_rf_write_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 2;
   localparam int NREG   = 4;
   localparam int SAT    = 3;

   logic              clk;
   logic              reset;
   logic              req0_valid;
   logic              req0_ready;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              rsv_valid;
   logic [ADDR_W-1:0] rsv_addr;
   logic              rsv_ready;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_write_addr;
   logic [DATA_W-1:0] rf_write_data;
   logic [NREG-1:0]   busy;

   rf_write_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_addr     (req0_addr),
      .req0_data     (req0_data),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_addr     (req1_addr),
      .req1_data     (req1_data),
      .rsv_valid     (rsv_valid),
      .rsv_addr      (rsv_addr),
      .rsv_ready     (rsv_ready),
      .rf_write      (rf_write),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .busy          (busy)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   int  pend [NREG];     // outstanding reservations per register
   bit  prefer1;         // req1 wins the next contention
   bit  acc0, acc1;      // acceptances seen in the cycle just modelled

   always @(negedge clk) begin
      bit              g0, g1, wb, exp_rsv_rdy, rfire;
      logic [ADDR_W-1:0] waddr;
      logic [NREG-1:0] exp_busy;
      acc0 = 0;
      acc1 = 0;
      if (reset) begin
         foreach (pend[i]) pend[i] = 0;
         prefer1 = 0;
      end else begin
         exp_busy = '0;
         foreach (pend[i]) exp_busy[i] = (pend[i] > 0);
         chk("busy", 32'(busy), 32'(exp_busy));

         if (req0_valid && req1_valid) begin
            g0 = !prefer1;
            g1 = prefer1;
         end else begin
            g0 = req0_valid;
            g1 = req1_valid;
         end
         chk("req0_ready", 32'(req0_ready), 32'(g0));
         chk("req1_ready", 32'(req1_ready), 32'(g1));

         wb    = g0 || g1;
         waddr = g0 ? req0_addr : req1_addr;
         if (g0) exp_q.push_back({req0_addr, req0_data});
         if (g1) exp_q.push_back({req1_addr, req1_data});

         exp_rsv_rdy = (pend[rsv_addr] < SAT) || (wb && waddr == rsv_addr);
         chk("rsv_ready", 32'(rsv_ready), 32'(exp_rsv_rdy));
         rfire = rsv_valid && exp_rsv_rdy;

         if (!(rfire && wb && rsv_addr == waddr)) begin
            if (wb && pend[waddr] > 0) pend[waddr] = pend[waddr] - 1;
            if (rfire) pend[rsv_addr] = pend[rsv_addr] + 1;
         end
`ifdef RF_ARB_ROUND_ROBIN_EN
         if (g0) prefer1 = 1;
         if (g1) prefer1 = 0;
`endif
         acc0 = g0;
         acc1 = g1;
      end
   end

   // ---------------- monitor ----------------
   logic [ADDR_W+DATA_W-1:0] got_e;
   always @(posedge clk) begin
      #2;
      if (rf_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(rf_write), 32'd0);
         end else begin
            got_e = exp_q.pop_front();
            chk("wr_addr", 32'(rf_write_addr), 32'(got_e[ADDR_W+DATA_W-1:DATA_W]));
            chk("wr_data", 32'(rf_write_data), 32'(got_e[DATA_W-1:0]));
         end
      end else begin
         chk("rf_write", 32'(rf_write), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) got_e = exp_q.pop_front();
      end
   end

   // ---------------- driver tasks ----------------
   // Advance one cycle; accepted requesters drop valid, unaccepted ones hold.
   task automatic step();
      @(posedge clk);
      #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      rsv_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic put0(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req0_valid = 1'b1;
      req0_addr  = a;
      req0_data  = d;
   endtask

   task automatic put1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req1_valid = 1'b1;
      req1_addr  = a;
      req1_data  = d;
   endtask

   task automatic rsv(input logic [ADDR_W-1:0] a);
      rsv_valid = 1'b1;
      rsv_addr  = a;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      rsv_valid  = 1'b0; rsv_addr  = '0;
      idle(2);
      reset = 1'b0;
      idle(3);
      chk("rst_wr_addr", 32'(rf_write_addr), 32'd0);
      chk("rst_wr_data", 32'(rf_write_data), 32'd0);

      // single write
      put0(2'd2, 16'hBEEF); step();
      idle(2);

      // lone req1 grant (unreserved write to r0), then contention
      put1(2'd0, 16'hA0A0); step();
      idle(1);
      put0(2'd1, 16'h1111);
      put1(2'd3, 16'h3333);
      step();
      step();
      idle(2);

      // scoreboard saturation on r0
      rsv(2'd0); step();
      rsv(2'd0); step();
      rsv(2'd0); step();
      rsv(2'd0); step();                          // refused: count is full
      rsv(2'd0); put1(2'd0, 16'h0C0C); step();    // accepted alongside write
      put0(2'd0, 16'h0001); step();
      put0(2'd0, 16'h0002); step();
      put0(2'd0, 16'h0003); step();
      idle(1);

      // same-cycle reserve/writeback
      rsv(2'd2); step();
      rsv(2'd2); put0(2'd2, 16'h2222); step();
      rsv(2'd1); put0(2'd2, 16'h2020); step();
      idle(1);

      // reset right after an acceptance, then an unreserved write
      put0(2'd3, 16'h00FF); step();
      reset = 1'b1; step();
      reset = 1'b0;
      idle(1);
      put0(2'd1, 16'h5A5A); step();
      idle(2);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         if (!req0_valid && $urandom_range(0, 2) == 0)
            put0(ADDR_W'($urandom_range(0, NREG-1)), DATA_W'($urandom_range(0, 65535)));
         if (!req1_valid && $urandom_range(0, 2) == 0)
            put1(ADDR_W'($urandom_range(0, NREG-1)), DATA_W'($urandom_range(0, 65535)));
         if ($urandom_range(0, 1) == 1) rsv(ADDR_W'($urandom_range(0, NREG-1)));
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
